// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register writeback front end.
package reg_wb_pkg;

    // Load sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite
    } wb_state_e;

    // Load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Index of the final byte lane for a load size; 011/11x count as a word.
    function automatic logic [1:0] last_lane(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   last_lane = 2'd0;
            2'b01:   last_lane = 2'd1;
            default: last_lane = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bundled ALU/load inputs and register-file write outputs for reg_writeback.
// Optional bypass outputs exist only when REG_WB_FORWARD_EN is defined.
interface reg_wb_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_result;
    logic              load_start;
    logic [REG_AW-1:0] load_rd;
    logic [2:0]        load_funct3;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [REG_AW-1:0] write_register;
    logic [XLEN-1:0]   write_value;
    logic              busy;
    logic              load_done;
    logic              protocol_err;
`ifdef REG_WB_FORWARD_EN
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_value;
`endif

    // Producer side: ALU, load sequencer and register file.
    modport master (
        output alu_valid, alu_rd, alu_result, load_start, load_rd, load_funct3,
               byte_valid, byte_data,
`ifdef REG_WB_FORWARD_EN
        input  fwd_valid, fwd_rd, fwd_value,
`endif
        input  write_register, write_value, busy, load_done, protocol_err
    );

    // Writeback block side.
    modport slave (
        input  alu_valid, alu_rd, alu_result, load_start, load_rd, load_funct3,
               byte_valid, byte_data,
`ifdef REG_WB_FORWARD_EN
        output fwd_valid, fwd_rd, fwd_value,
`endif
        output write_register, write_value, busy, load_done, protocol_err
    );

endinterface

// File: rtl/reg_writeback_load_extend.sv
// Sign/zero extension of an assembled load according to funct3.
module load_extend #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] asm_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] value_o
);

    // funct3[2] selects zero extension; word loads pass through.
    always_comb begin
        value_o = asm_i;
        unique case (funct3_i[1:0])
            2'b00:   value_o = {{(XLEN-8){~funct3_i[2] & asm_i[7]}}, asm_i[7:0]};
            2'b01:   value_o = {{(XLEN-16){~funct3_i[2] & asm_i[15]}}, asm_i[15:0]};
            default: value_o = asm_i;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write port arbiter: ALU results win, byte-serial loads are
// assembled, extended and written when the port is free.
// Define REG_WB_FORWARD_EN to expose the next-edge write as bypass outputs.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic    clk,
    input  logic    rst,
    reg_wb_if.slave wb
);

    wb_state_e         state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   asm_q, asm_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              cancel_q, cancel_d;
    logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
    logic [XLEN-1:0]   wr_val_q, wr_val_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   ext_value;
    logic              alu_wr;

    assign alu_wr = wb.alu_valid && (wb.alu_rd != '0);

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .asm_i    (asm_q),
        .funct3_i (f3_q),
        .value_o  (ext_value)
    );

    // Next-state: load sequencing, port arbitration and WAW cancellation.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        f3_d     = f3_q;
        asm_d    = asm_q;
        cnt_d    = cnt_q;
        cancel_d = cancel_q;
        err_d    = err_q;
        wr_reg_d = '0;
        wr_val_d = '0;
        done_d   = 1'b0;

        if (alu_wr) begin
            wr_reg_d = wb.alu_rd;
            wr_val_d = wb.alu_result;
        end
        // A younger ALU write to the load's rd makes the load result stale.
        if ((state_q != StIdle) && alu_wr && (wb.alu_rd == rd_q)) begin
            cancel_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (wb.byte_valid) err_d = 1'b1;
                if (wb.load_start) begin
                    rd_d     = wb.load_rd;
                    f3_d     = wb.load_funct3;
                    asm_d    = '0;
                    cnt_d    = '0;
                    cancel_d = 1'b0;
                    state_d  = StCollect;
                end
            end
            StCollect: begin
                if (wb.load_start) err_d = 1'b1;
                if (wb.byte_valid) begin
                    asm_d[{cnt_q, 3'b000} +: 8] = wb.byte_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_lane(f3_q)) state_d = StWrite;
                end
            end
            StWrite: begin
                if (wb.load_start || wb.byte_valid) err_d = 1'b1;
                if (!alu_wr) begin
                    if (!cancel_q && (rd_q != '0)) begin
                        wr_reg_d = rd_q;
                        wr_val_d = ext_value;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rd_q     <= '0;
            f3_q     <= '0;
            asm_q    <= '0;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
            wr_reg_q <= '0;
            wr_val_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            f3_q     <= f3_d;
            asm_q    <= asm_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
            wr_reg_q <= wr_reg_d;
            wr_val_q <= wr_val_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign wb.write_register = wr_reg_q;
    assign wb.write_value    = wr_val_q;
    assign wb.busy           = (state_q != StIdle);
    assign wb.load_done      = done_q;
    assign wb.protocol_err   = err_q;

`ifdef REG_WB_FORWARD_EN
    // Bypass copy of the write that the next edge will present.
    assign wb.fwd_valid = (wr_reg_d != '0);
    assign wb.fwd_rd    = wr_reg_d;
    assign wb.fwd_value = wr_val_d;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: load vector table plus hand-written
// collision, WAW, protocol and reset sequences, with a write scoreboard.
module tb_reg_writeback;
    import reg_wb_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic [4:0]  rd;
        int unsigned n;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    wr_t  exp_q[$];
    vec_t vecs[9];

    reg_wb_if wb_if ();

    reg_writeback dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] val);
        wr_t w;
        w.rd  = rd;
        w.val = val;
        exp_q.push_back(w);
    endtask

    // Every non-zero write must match the oldest expected write, in order.
    always @(negedge clk) begin
        if (!rst && wb_if.write_register != '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", {27'd0, wb_if.write_register}, 32'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("sb_rd", {27'd0, wb_if.write_register}, {27'd0, w.rd});
                check("sb_val", wb_if.write_value, w.val);
            end
        end
    end

    task automatic idle_inputs();
        wb_if.alu_valid   = 1'b0;
        wb_if.alu_rd      = '0;
        wb_if.alu_result  = '0;
        wb_if.load_start  = 1'b0;
        wb_if.load_rd     = '0;
        wb_if.load_funct3 = '0;
        wb_if.byte_valid  = 1'b0;
        wb_if.byte_data   = '0;
    endtask

    task automatic start_load(input logic [2:0] f3, input logic [4:0] rd);
        wb_if.load_start  = 1'b1;
        wb_if.load_rd     = rd;
        wb_if.load_funct3 = f3;
        tick();
        wb_if.load_start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        wb_if.byte_valid = 1'b1;
        wb_if.byte_data  = b;
        tick();
        wb_if.byte_valid = 1'b0;
    endtask

    // Full uncontended load: write and done appear one cycle after the last byte.
    task automatic do_load(input vec_t v);
        if (v.rd != '0) push(v.rd, v.exp);
        start_load(v.f3, v.rd);
        check("ld_busy", {31'd0, wb_if.busy}, 32'd1);
        for (int i = 0; i < int'(v.n); i++) send_byte(v.data[8*i +: 8]);
        check("ld_not_done_yet", {31'd0, wb_if.load_done}, 32'd0);
        tick();
        check("ld_done", {31'd0, wb_if.load_done}, 32'd1);
        check("ld_busy_clr", {31'd0, wb_if.busy}, 32'd0);
        check("ld_wr_rd", {27'd0, wb_if.write_register}, {27'd0, v.rd});
        tick();
        check("ld_done_pulse", {31'd0, wb_if.load_done}, 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{F3_LB,  5'd2,  1, 32'h0000_0080, 32'hFFFF_FF80};
        vecs[1] = '{F3_LBU, 5'd2,  1, 32'h0000_0080, 32'h0000_0080};
        vecs[2] = '{F3_LW,  5'd4,  4, 32'h4433_2211, 32'h4433_2211};
        vecs[3] = '{F3_LH,  5'd5,  2, 32'h0000_9234, 32'hFFFF_9234};
        vecs[4] = '{F3_LHU, 5'd5,  2, 32'h0000_9234, 32'h0000_9234};
        vecs[5] = '{F3_LB,  5'd12, 1, 32'h0000_007F, 32'h0000_007F};
        vecs[6] = '{3'b011, 5'd13, 4, 32'h8000_0001, 32'h8000_0001};
        vecs[7] = '{3'b110, 5'd14, 4, 32'h0000_FF80, 32'h0000_FF80};
        vecs[8] = '{F3_LW,  5'd0,  4, 32'h1234_5678, 32'h1234_5678};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_wr_reg", {27'd0, wb_if.write_register}, 32'd0);
        check("rst_wr_val", wb_if.write_value, 32'd0);
        check("rst_busy", {31'd0, wb_if.busy}, 32'd0);
        check("rst_done", {31'd0, wb_if.load_done}, 32'd0);
        check("rst_err", {31'd0, wb_if.protocol_err}, 32'd0);

        // Single ALU write: one cycle, then the port returns to 0.
        push(5'd3, 32'hDEAD_BEEF);
        wb_if.alu_valid  = 1'b1;
        wb_if.alu_rd     = 5'd3;
        wb_if.alu_result = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        check("alu_rd", {27'd0, wb_if.write_register}, 32'd3);
        check("alu_val", wb_if.write_value, 32'hDEAD_BEEF);
        tick();
        check("alu_one_cycle", {27'd0, wb_if.write_register}, 32'd0);

        // Back-to-back ALU writes.
        for (int i = 0; i < 3; i++) begin
            push(5'(8 + i), 32'h100 + 32'(i));
            wb_if.alu_valid  = 1'b1;
            wb_if.alu_rd     = 5'(8 + i);
            wb_if.alu_result = 32'h100 + 32'(i);
            tick();
            check("alu_b2b_rd", {27'd0, wb_if.write_register}, 32'(8 + i));
        end
        idle_inputs();

        // ALU write to r0 is dropped.
        wb_if.alu_valid  = 1'b1;
        wb_if.alu_rd     = 5'd0;
        wb_if.alu_result = 32'h5555_5555;
        tick();
        idle_inputs();
        check("alu_r0_drop", {27'd0, wb_if.write_register}, 32'd0);
        tick();

        for (int i = 0; i < 9; i++) do_load(vecs[i]);

        // Collision in WRITE: ALU r1 goes first, the load follows one cycle later.
        start_load(F3_LW, 5'd6);
        send_byte(8'h0D);
        send_byte(8'hF0);
        send_byte(8'hFE);
        send_byte(8'hCA);
        push(5'd1, 32'd5);
        push(5'd6, 32'hCAFE_F00D);
        wb_if.alu_valid  = 1'b1;
        wb_if.alu_rd     = 5'd1;
        wb_if.alu_result = 32'd5;
        tick();
        idle_inputs();
        check("col_alu_rd", {27'd0, wb_if.write_register}, 32'd1);
        check("col_no_done", {31'd0, wb_if.load_done}, 32'd0);
        check("col_busy", {31'd0, wb_if.busy}, 32'd1);
        tick();
        check("col_ld_rd", {27'd0, wb_if.write_register}, 32'd6);
        check("col_ld_val", wb_if.write_value, 32'hCAFE_F00D);
        check("col_done", {31'd0, wb_if.load_done}, 32'd1);
        tick();

        // WAW: ALU write to the in-flight load's rd suppresses the load write.
        start_load(F3_LW, 5'd7);
        push(5'd7, 32'h0000_1234);
        wb_if.alu_valid  = 1'b1;
        wb_if.alu_rd     = 5'd7;
        wb_if.alu_result = 32'h0000_1234;
        wb_if.byte_valid = 1'b1;
        wb_if.byte_data  = 8'hAA;
        tick();
        idle_inputs();
        check("waw_alu_rd", {27'd0, wb_if.write_register}, 32'd7);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        tick();
        check("waw_done", {31'd0, wb_if.load_done}, 32'd1);
        check("waw_no_write", {27'd0, wb_if.write_register}, 32'd0);
        tick();

        // Protocol errors: stray byte in IDLE, then load_start while busy.
        check("err_clear_before", {31'd0, wb_if.protocol_err}, 32'd0);
        wb_if.byte_valid = 1'b1;
        wb_if.byte_data  = 8'h77;
        tick();
        idle_inputs();
        check("err_byte_idle", {31'd0, wb_if.protocol_err}, 32'd1);
        check("err_byte_idle_busy", {31'd0, wb_if.busy}, 32'd0);
        push(5'd9, 32'h0000_1234);
        start_load(F3_LH, 5'd9);
        wb_if.load_start  = 1'b1;
        wb_if.load_rd     = 5'd10;
        wb_if.load_funct3 = F3_LB;
        wb_if.byte_valid  = 1'b1;
        wb_if.byte_data   = 8'h34;
        tick();
        idle_inputs();
        send_byte(8'h12);
        tick();
        check("err_ld_rd", {27'd0, wb_if.write_register}, 32'd9);
        check("err_ld_val", wb_if.write_value, 32'h0000_1234);
        check("err_sticky", {31'd0, wb_if.protocol_err}, 32'd1);
        tick();

        // Asynchronous reset mid-load discards it; a following load works.
        start_load(F3_LW, 5'd11);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, wb_if.busy}, 32'd0);
        check("mid_rst_wr", {27'd0, wb_if.write_register}, 32'd0);
        check("mid_rst_err", {31'd0, wb_if.protocol_err}, 32'd0);
        check("mid_rst_done", {31'd0, wb_if.load_done}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_idle_wr", {27'd0, wb_if.write_register}, 32'd0);
        do_load('{F3_LW, 5'd11, 4, 32'hA1B2_C3D4, 32'hA1B2_C3D4});

        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side front end of the CPU register file. Merges single-cycle ALU results and multi-cycle memory loads, which arrive one byte at a time from the serial memory interface, onto the register file's single write port (`write_register`/`write_value`). It assembles load bytes, sign- or zero-extends them per funct3, and arbitrates against ALU writebacks. The register file treats `write_register == 0` as no write, so this block drives 0 whenever it is not writing.

## Interface
Parameters:
- `XLEN`, 32, data width
- `REG_AW`, 5, register index width

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_result`  in  32  ALU value
- `load_start`  in  1  begin a load (accepted only in IDLE)
- `load_rd`  in  5  load destination register
- `load_funct3`  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101
- `byte_valid`  in  1  one load byte present
- `byte_data`  in  8  load byte, least-significant first
- `write_register`  out  5  register file write index (0 = no write)
- `write_value`  out  32  register file write data
- `busy`  out  1  load in progress (state != IDLE)
- `load_done`  out  1  one-cycle pulse when a load completes
- `protocol_err`  out  1  sticky; set on `load_start` while busy, or `byte_valid` in IDLE

## Operation
- FSM states:
  - IDLE: `load_start` latches rd and funct3, clears the 32-bit assembly register and 2-bit byte counter, then goes to COLLECT.
  - COLLECT: each `byte_valid` stores `byte_data` at byte lane `cnt` and increments `cnt`. When the byte completing the load is accepted, go to WRITE. Byte count is 1 for funct3[1:0]=00, 2 for 01, and 4 otherwise (011/11x are treated as a word).
  - WRITE: the load writes back at the first edge without an ALU write, then the FSM returns to IDLE.
- Extension: the byte load uses bit 7 and the half load uses bit 15. Both sign-extend when funct3[2]=0 and zero-extend when funct3[2]=1. Word loads pass through unchanged.
- Arbitration: an ALU write with `alu_rd != 0` always wins the port. A pending load in WRITE waits.
- WAW: an ALU write to the latched load rd while `busy` cancels that load's write. Bytes are still consumed and `load_done` still pulses.
- A load with rd=0 runs normally, writes nothing, and pulses `load_done`.
- An ALU write with `alu_rd == 0` is dropped.
- `byte_valid` in IDLE or WRITE is ignored and sets `protocol_err`. `load_start` outside IDLE is ignored and sets `protocol_err`.
- `protocol_err` is cleared only by `rst`.

## Timing
- All outputs are registered.
- Reset values: `write_register`=0, `write_value`=0, `busy`=0, `load_done`=0, `protocol_err`=0, FSM=IDLE, counter=0. Reset mid-load discards the load with no write.
- ALU path: if `alu_valid` is sampled at edge k, `write_register`/`write_value` are valid for exactly one cycle after edge k. The register file captures the value at edge k+1.
- Load path: if the final byte is sampled at edge k, state=WRITE after k. If no ALU write occurs at edge k+1, the write is presented after edge k+1, together with the `load_done` pulse and `busy`=0.
- Each cycle of ALU collision in WRITE adds one cycle of delay. `load_done` always coincides with the load's write cycle, or with the cancelled slot.
- `load_start` sampled in IDLE makes `busy`=1 the next cycle. `byte_valid` may arrive in the cycle immediately after that.
- Back-to-back ALU writes sustain one write per cycle.

## Configuration
- `REG_WB_FORWARD_EN`: adds outputs `fwd_valid` (1), `fwd_rd` (5) and `fwd_value` (32). These are combinational copies of the value to be written at the next edge, so decode can bypass the register file by one cycle. They follow the same arbitration and WAW rules.
- Without the macro these ports do not exist, and the write latency is as stated in Timing.

## Structure
- Shared package `reg_wb_pkg`:
  - FSM state enum (IDLE, COLLECT, WRITE)
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - helper constant for byte count by size
- One sub-module, `load_extend`: combinational; takes the assembly register and funct3 and returns the extended 32-bit value.

## Test plan
- ALU only: `alu_valid`, rd=3, result 0xDEADBEEF -> next cycle `write_register`=3, `write_value`=0xDEADBEEF for one cycle, then 0.
- LB, rd=2, byte 0x80 -> write 0xFFFFFF80 to r2, `load_done` pulse. LBU with the same byte -> 0x00000080.
- LW, rd=4, bytes 0x11,0x22,0x33,0x44 -> write 0x44332211. LH with bytes 0x34,0x92 -> 0xFFFF9234.
- Collision: load in WRITE plus `alu_valid` rd=1 value 5 -> r1=5 first, load written one cycle later. ALU to the same rd as an in-flight load -> the load write is suppressed and `load_done` still pulses.
- Protocol: `load_start` while busy, and `byte_valid` in IDLE -> `protocol_err`=1 and sticky, with state and assembly unchanged.
- Reset: assert `rst` after 2 of 4 LW bytes -> all outputs 0 and IDLE. A subsequent LW works normally.
